tf_gen: RTL and testbench



---
 rtl/tf_pkg.sv | 39 +++
 rtl/tf_modmul.sv | 42 ++++
 rtl/tf_gen.sv | 155 +++++++++++++++
 tb/tb_tf_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tf_pkg.sv
// ============================================================================
// Module      : tf_pkg
// Description : Shared constants, types and init tables for the twiddle
//               generator (forward and inverse NTT, used with TF_INV_EN).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tf_pkg;

    localparam int TF_W   = 32;
    localparam int STAGES = 3;

    typedef logic [TF_W-1:0] tf_t;

    localparam tf_t Q = 32'd12289;

    // floor(2^(2k) / q), widened so any k up to 63 is representable
    function automatic logic [127:0] barrett_mu(input int unsigned k, input logic [63:0] q);
        logic [127:0] num;
        num = 128'd1 << (2 * k);
        return num / {64'd0, q};
    endfunction

    localparam logic [127:0] MU = barrett_mu(TF_W, 64'(Q));

    // Tables are worked for the Q=97 bring-up modulus; inverse entries are
    // the modular inverses of the forward ones.
    localparam tf_t BASE_INIT  [STAGES] = '{32'd1, 32'd1, 32'd1};
    localparam tf_t STEP_INIT  [STAGES] = '{32'd2, 32'd34, 32'd5};
    localparam tf_t GSTEP_INIT [STAGES] = '{32'd7, 32'd3, 32'd11};

    localparam tf_t BASE_INV   [STAGES] = '{32'd1, 32'd1, 32'd1};
    localparam tf_t STEP_INV   [STAGES] = '{32'd49, 32'd20, 32'd39};
    localparam tf_t GSTEP_INV  [STAGES] = '{32'd14, 32'd65, 32'd53};

endpackage

`default_nettype wire

// File: rtl/tf_modmul.sv
// ============================================================================
// Module      : tf_modmul
// Description : Combinational a*b mod Q using Barrett reduction (k = TF_W).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tf_modmul
    import tf_pkg::*;
#(
    parameter int              TF_W = 32,
    parameter logic [TF_W-1:0] Q    = TF_W'(tf_pkg::Q)
) (
    input  logic [TF_W-1:0] a,
    input  logic [TF_W-1:0] b,
    output logic [TF_W-1:0] r
);

    localparam int            PW   = 2 * TF_W;
    localparam int            RW   = TF_W + 1;
    localparam logic [PW-1:0] C_MU = PW'(barrett_mu(TF_W, 64'(Q)));

    logic [PW-1:0] w_x;
    logic [PW-1:0] w_qe;
    logic [RW-1:0] w_r0;
    logic [RW-1:0] w_r1;
    logic [RW-1:0] w_r2;

    assign w_x  = PW'(a) * PW'(b);
    assign w_qe = PW'(((2 * PW)'(w_x) * (2 * PW)'(C_MU)) >> PW);

    // Quotient estimate is low by at most 2, so the remainder is below 3Q
    // and fits in TF_W+1 bits; the modular subtraction is exact there.
    assign w_r0 = RW'(w_x - w_qe * PW'(Q));
    assign w_r1 = (w_r0 >= RW'(Q)) ? (w_r0 - RW'(Q)) : w_r0;
    assign w_r2 = (w_r1 >= RW'(Q)) ? (w_r1 - RW'(Q)) : w_r1;

    assign r = w_r2[TF_W-1:0];

endmodule

`default_nettype wire

// File: rtl/tf_gen.sv
// ============================================================================
// Module      : tf_gen
// Description : Per-stage twiddle-factor generator driven by the NTT
//               controller's TF_* strobes. Optional macro TF_INV_EN adds
//               the tf_inv port selecting the inverse-NTT init tables.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tf_gen
    import tf_pkg::*;
#(
    parameter int              TF_W   = 32,
    parameter int              D_W    = 16,
    parameter int              STAGES = 3,
    parameter logic [TF_W-1:0] Q      = TF_W'(tf_pkg::Q)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            TF_init_base,
    input  logic            TF_init_const,
    input  logic            TF_ren,
    input  logic            TF_wen,
`ifdef TF_INV_EN
    input  logic            tf_inv,
`endif
    input  logic [D_W-1:0]  it_depth_cnt,
    output logic [TF_W-1:0] tf_out,
    output logic            tf_valid,
    output logic [D_W-1:0]  tf_stage,
    output logic            tf_err
);

    localparam int IW    = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int PKG_S = tf_pkg::STAGES;

    logic [TF_W-1:0] r_base  [STAGES];
    logic [TF_W-1:0] r_cur   [STAGES];
    logic [TF_W-1:0] r_step  [STAGES];
    logic [TF_W-1:0] r_gstep [STAGES];
    logic            r_const_ok;
    logic            r_base_ok;
    logic [TF_W-1:0] r_out;
    logic            r_valid;
    logic [D_W-1:0]  r_stage;
    logic            r_err;

    logic [TF_W-1:0] w_base_init  [STAGES];
    logic [TF_W-1:0] w_step_init  [STAGES];
    logic [TF_W-1:0] w_gstep_init [STAGES];
    logic            w_init;
    logic            w_stage_ok;
    logic            w_legal;
    logic [IW-1:0]   w_idx;
    logic [TF_W-1:0] w_adv;
    logic [TF_W-1:0] w_nb;

    // Stages beyond the package tables initialise to zero
    for (genvar s = 0; s < STAGES; s++) begin : g_init
        localparam int  PS  = s % PKG_S;
        localparam bit  HAS = (s < PKG_S);
`ifdef TF_INV_EN
        assign w_base_init[s]  = !HAS ? '0 : tf_inv ? TF_W'(BASE_INV[PS])  : TF_W'(BASE_INIT[PS]);
        assign w_step_init[s]  = !HAS ? '0 : tf_inv ? TF_W'(STEP_INV[PS])  : TF_W'(STEP_INIT[PS]);
        assign w_gstep_init[s] = !HAS ? '0 : tf_inv ? TF_W'(GSTEP_INV[PS]) : TF_W'(GSTEP_INIT[PS]);
`else
        assign w_base_init[s]  = HAS ? TF_W'(BASE_INIT[PS])  : '0;
        assign w_step_init[s]  = HAS ? TF_W'(STEP_INIT[PS])  : '0;
        assign w_gstep_init[s] = HAS ? TF_W'(GSTEP_INIT[PS]) : '0;
`endif
    end

    assign w_init     = TF_init_base | TF_init_const;
    assign w_stage_ok = (it_depth_cnt < D_W'(STAGES));
    assign w_legal    = w_stage_ok & r_const_ok & r_base_ok;
    assign w_idx      = w_stage_ok ? it_depth_cnt[IW-1:0] : '0;

    tf_modmul #(.TF_W(TF_W), .Q(Q)) u_mul_adv (
        .a (r_cur[w_idx]),
        .b (r_step[w_idx]),
        .r (w_adv)
    );

    tf_modmul #(.TF_W(TF_W), .Q(Q)) u_mul_grp (
        .a (r_base[w_idx]),
        .b (r_gstep[w_idx]),
        .r (w_nb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_base[i]  <= '0;
                r_cur[i]   <= '0;
                r_step[i]  <= '0;
                r_gstep[i] <= '0;
            end
            r_const_ok <= 1'b0;
            r_base_ok  <= 1'b0;
            r_out      <= '0;
            r_valid    <= 1'b0;
            r_stage    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_init) begin
                if (TF_init_const) begin
                    for (int i = 0; i < STAGES; i++) begin
                        r_step[i]  <= w_step_init[i];
                        r_gstep[i] <= w_gstep_init[i];
                    end
                    r_const_ok <= 1'b1;
                end
                if (TF_init_base) begin
                    for (int i = 0; i < STAGES; i++) begin
                        r_base[i] <= w_base_init[i];
                        r_cur[i]  <= w_base_init[i];
                    end
                    r_base_ok <= 1'b1;
                end
            end else if (TF_ren || TF_wen) begin
                if (!w_legal) begin
                    r_err <= 1'b1;
                    if (TF_ren) begin
                        r_out   <= '0;
                        r_valid <= 1'b1;
                        r_stage <= it_depth_cnt;
                    end
                end else begin
                    if (TF_ren) begin
                        r_out   <= r_cur[w_idx];
                        r_valid <= 1'b1;
                        r_stage <= it_depth_cnt;
                    end
                    // A re-base in the same cycle as a read suppresses the advance
                    if (TF_wen) begin
                        r_base[w_idx] <= w_nb;
                        r_cur[w_idx]  <= w_nb;
                    end else begin
                        r_cur[w_idx]  <= w_adv;
                    end
                end
            end
        end
    end

    assign tf_out   = r_out;
    assign tf_valid = r_valid;
    assign tf_stage = r_stage;
    assign tf_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tf_gen.sv
// ============================================================================
// Module      : tb_tf_gen
// Description : Directed self-checking bench for tf_gen (Q = 97).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tf_gen;

    localparam int TF_W = 32;
    localparam int D_W  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            TF_init_base = 1'b0;
    logic            TF_init_const = 1'b0;
    logic            TF_ren = 1'b0;
    logic            TF_wen = 1'b0;
`ifdef TF_INV_EN
    logic            tf_inv = 1'b0;
`endif
    logic [D_W-1:0]  it_depth_cnt = '0;
    logic [TF_W-1:0] tf_out;
    logic            tf_valid;
    logic [D_W-1:0]  tf_stage;
    logic            tf_err;

    logic [TF_W-1:0] mm_a = '0;
    logic [TF_W-1:0] mm_b = '0;
    logic [TF_W-1:0] mm_r;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tf_gen #(.TF_W(TF_W), .D_W(D_W), .STAGES(3), .Q(32'd97)) dut (
        .clk           (clk),
        .rst           (rst),
        .TF_init_base  (TF_init_base),
        .TF_init_const (TF_init_const),
        .TF_ren        (TF_ren),
        .TF_wen        (TF_wen),
`ifdef TF_INV_EN
        .tf_inv        (tf_inv),
`endif
        .it_depth_cnt  (it_depth_cnt),
        .tf_out        (tf_out),
        .tf_valid      (tf_valid),
        .tf_stage      (tf_stage),
        .tf_err        (tf_err)
    );

    tf_modmul #(.TF_W(TF_W), .Q(32'd97)) u_mm (
        .a (mm_a),
        .b (mm_b),
        .r (mm_r)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int stage, input int exp_out, input string tag);
        it_depth_cnt = D_W'(stage);
        TF_ren = 1'b1;
        tick();
        TF_ren = 1'b0;
        chk({tag, "_out"},   64'(tf_out),   64'(exp_out));
        chk({tag, "_valid"}, 64'(tf_valid), 64'd1);
        chk({tag, "_stage"}, 64'(tf_stage), 64'(stage));
        chk({tag, "_err"},   64'(tf_err),   64'd0);
    endtask

    task automatic init_all();
        TF_init_base  = 1'b1;
        TF_init_const = 1'b1;
        tick();
        TF_init_base  = 1'b0;
        TF_init_const = 1'b0;
    endtask

    initial begin
        int exp_seq[8];
        exp_seq = '{1, 2, 4, 8, 16, 32, 64, 31};

        tick(); tick();
        rst = 1'b0;
        chk("rst_out",   64'(tf_out),   64'd0);
        chk("rst_valid", 64'(tf_valid), 64'd0);
        chk("rst_stage", 64'(tf_stage), 64'd0);
        chk("rst_err",   64'(tf_err),   64'd0);

        // accesses before any init are illegal
        it_depth_cnt = '0; TF_ren = 1'b1; tick(); TF_ren = 1'b0;
        chk("noinit_rd_out",   64'(tf_out),   64'd0);
        chk("noinit_rd_valid", 64'(tf_valid), 64'd1);
        chk("noinit_rd_err",   64'(tf_err),   64'd1);
        TF_wen = 1'b1; tick(); TF_wen = 1'b0;
        chk("noinit_wr_err",   64'(tf_err),   64'd1);
        chk("noinit_wr_valid", 64'(tf_valid), 64'd0);

        // init held two cycles with a read strobe that must be ignored
        TF_init_base = 1'b1; TF_init_const = 1'b1; TF_ren = 1'b1;
        tick();
        chk("init_ren_valid", 64'(tf_valid), 64'd0);
        chk("init_ren_err",   64'(tf_err),   64'd0);
        tick();
        TF_init_base = 1'b0; TF_init_const = 1'b0; TF_ren = 1'b0;

        for (int i = 0; i < 8; i++) rd(0, exp_seq[i], $sformatf("s0_rd%0d", i));

        rd(1, 1, "s1_rd0");
        rd(1, 34, "s1_rd1");
        it_depth_cnt = 16'd1; TF_wen = 1'b1; tick(); TF_wen = 1'b0;
        chk("s1_wen_valid", 64'(tf_valid), 64'd0);
        chk("s1_wen_err",   64'(tf_err),   64'd0);
        rd(1, 3, "s1_rebased");
        rd(0, 62, "s0_untouched");

        // combined read and re-base: old cur out, no advance
        it_depth_cnt = 16'd1; TF_ren = 1'b1; TF_wen = 1'b1; tick();
        TF_ren = 1'b0; TF_wen = 1'b0;
        chk("rw_out",   64'(tf_out),   64'd5);
        chk("rw_valid", 64'(tf_valid), 64'd1);
        rd(1, 9, "rw_next");

        it_depth_cnt = 16'd3; TF_ren = 1'b1; tick(); TF_ren = 1'b0;
        chk("bad_rd_out",   64'(tf_out),   64'd0);
        chk("bad_rd_valid", 64'(tf_valid), 64'd1);
        chk("bad_rd_err",   64'(tf_err),   64'd1);
        chk("bad_rd_stage", 64'(tf_stage), 64'd3);
        rd(1, 15, "after_bad_rd");

        it_depth_cnt = 16'd5; TF_wen = 1'b1; tick(); TF_wen = 1'b0;
        chk("bad_wr_err",   64'(tf_err),   64'd1);
        chk("bad_wr_valid", 64'(tf_valid), 64'd0);
        rd(0, 27, "after_bad_wr");

        tick();
        chk("idle_valid", 64'(tf_valid), 64'd0);
        chk("idle_hold",  64'(tf_out),   64'd27);

        // reset mid-operation
        it_depth_cnt = 16'd2; TF_ren = 1'b1; rst = 1'b1; tick();
        rst = 1'b0; TF_ren = 1'b0;
        chk("mid_rst_out",   64'(tf_out),   64'd0);
        chk("mid_rst_valid", 64'(tf_valid), 64'd0);
        chk("mid_rst_stage", 64'(tf_stage), 64'd0);
        chk("mid_rst_err",   64'(tf_err),   64'd0);
        it_depth_cnt = 16'd0; TF_ren = 1'b1; tick(); TF_ren = 1'b0;
        chk("post_rst_err", 64'(tf_err), 64'd1);
        chk("post_rst_out", 64'(tf_out), 64'd0);

        init_all();
        rd(0, 1, "reinit_rd0");
        rd(0, 2, "reinit_rd1");
        rd(2, 1, "reinit_s2_rd0");
        rd(2, 5, "reinit_s2_rd1");

`ifdef TF_INV_EN
        tf_inv = 1'b1;
        init_all();
        tf_inv = 1'b0;
        rd(0, 1, "inv_rd0");
        rd(0, 49, "inv_rd1");
`endif

        // modular multiplier against a % reference
        mm_a = 32'd96; mm_b = 32'd96; #1;
        chk("mm_qm1_sq", 64'(mm_r), 64'd1);
        mm_a = 32'd0; mm_b = 32'd55; #1;
        chk("mm_zero", 64'(mm_r), 64'd0);
        for (int i = 0; i < 24; i++) begin
            int unsigned a, b;
            a = $urandom_range(96, 0);
            b = $urandom_range(96, 0);
            mm_a = TF_W'(a); mm_b = TF_W'(b); #1;
            chk($sformatf("mm_rand%0d_%0dx%0d", i, a, b), 64'(mm_r), 64'((a * b) % 97));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
